bin2bcd_seq: RTL and testbench

Sequential binary-to-BCD converter (shift-and-add-3) feeding the multiplexed 7-segment display driver. Accepts an unsigned binary value on a start strobe and, after a fixed number of cycles, presents up to nine stable 4-bit decimal digits. Those digits connect directly to the display driver's nibble inputs. Outputs change only on completion, so the display never shows partial results.

---
 rtl/bin2bcd_seq_pkg.sv | 14 +
 rtl/bin2bcd_seq_bcd_add3.sv | 9 +
 rtl/bin2bcd_seq.sv | 141 ++++++++++++++
 tb/tb_bin2bcd_seq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_seq_pkg.sv
// Shared constants and FSM encoding for the sequential binary-to-BCD converter.
package bin2bcd_seq_pkg;

    localparam int BCD_W      = 4;
    localparam int SCR_DIGITS = 10;
    localparam int MAX_DIGITS = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bin2bcd_seq_bcd_add3.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3 before the shift.
module bcd_add3 (
    input  logic [3:0] digit,
    output logic [3:0] adj
);

    assign adj = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with registered digit outputs.
// BIN2BCD_OVF_SAT_EN: on overflow show all nines instead of the value modulo 10^DIGITS.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int DIGITS = 8,
    parameter int BIN_W  = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [3:0]       D0,
    output logic [3:0]       D1,
    output logic [3:0]       D2,
    output logic [3:0]       D3,
    output logic [3:0]       D4,
    output logic [3:0]       D5,
    output logic [3:0]       D6,
    output logic [3:0]       D7,
    output logic [3:0]       D8
);

    localparam int               CNT_W    = $clog2(BIN_W);
    localparam int               SCR_W    = SCR_DIGITS * BCD_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    state_t           state;
    state_t           state_nxt;
    logic             load;
    logic             shift_en;
    logic             finish;
    logic [CNT_W-1:0] cnt;
    logic [BIN_W-1:0] sr;
    logic [SCR_W-1:0] scratch;
    logic [SCR_W-1:0] adj;
    logic             ovf_c;
    logic [BCD_W-1:0] dig [MAX_DIGITS];

    function automatic logic [BCD_W-1:0] sat_digit(input logic [BCD_W-1:0] d,
                                                   input logic            over);
`ifdef BIN2BCD_OVF_SAT_EN
        return over ? 4'd9 : d;
`else
        return (over === 1'bx) ? d : d;
`endif
    endfunction

    for (genvar g = 0; g < SCR_DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit(scratch[g*BCD_W +: BCD_W]),
            .adj  (adj[g*BCD_W +: BCD_W])
        );
    end

    always_comb begin
        ovf_c = 1'b0;
        for (int i = 0; i < SCR_DIGITS; i++) begin
            if (i >= DIGITS && scratch[i*BCD_W +: BCD_W] != '0) ovf_c = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Encoding 2'b11 is unreachable; it falls back to IDLE via the default arm.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift_en  = 1'b0;
        finish    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_en = 1'b1;
                if (cnt == CNT_LAST) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                finish    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr      <= '0;
            scratch <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ovf     <= 1'b0;
            for (int k = 0; k < MAX_DIGITS; k++) dig[k] <= '0;
        end else begin
            done <= 1'b0;
            if (load) begin
                sr      <= bin;
                scratch <= '0;
                cnt     <= '0;
                busy    <= 1'b1;
            end
            if (shift_en) begin
                scratch <= {adj[SCR_W-2:0], sr[BIN_W-1]};
                sr      <= sr << 1;
                cnt     <= cnt + CNT_W'(1);
            end
            // Digits and ovf only move here, so the display never sees a partial result.
            if (finish) begin
                for (int k = 0; k < MAX_DIGITS; k++) begin
                    if (k < DIGITS) dig[k] <= sat_digit(scratch[k*BCD_W +: BCD_W], ovf_c);
                    else            dig[k] <= '0;
                end
                ovf  <= ovf_c;
                done <= 1'b1;
                busy <= 1'b0;
            end
        end
    end

    assign D0 = dig[0];
    assign D1 = dig[1];
    assign D2 = dig[2];
    assign D3 = dig[3];
    assign D4 = dig[4];
    assign D5 = dig[5];
    assign D6 = dig[6];
    assign D7 = dig[7];
    assign D8 = dig[8];

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: a 27-bit/8-digit and a 32-bit/9-digit instance.
module tb_bin2bcd_seq;

    typedef struct packed {
        logic             ovf;
        logic [8:0][3:0]  d;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start_a = 1'b0;
    logic            start_b = 1'b0;
    logic [26:0]     bin_a = '0;
    logic [31:0]     bin_b = '0;
    logic            busy_a, done_a, ovf_a;
    logic            busy_b, done_b, ovf_b;
    logic [8:0][3:0] da, db;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bin2bcd_seq #(.DIGITS(8), .BIN_W(27)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .bin(bin_a),
        .busy(busy_a), .done(done_a), .ovf(ovf_a),
        .D0(da[0]), .D1(da[1]), .D2(da[2]), .D3(da[3]), .D4(da[4]),
        .D5(da[5]), .D6(da[6]), .D7(da[7]), .D8(da[8])
    );

    bin2bcd_seq #(.DIGITS(9), .BIN_W(32)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .bin(bin_b),
        .busy(busy_b), .done(done_b), .ovf(ovf_b),
        .D0(db[0]), .D1(db[1]), .D2(db[2]), .D3(db[3]), .D4(db[4]),
        .D5(db[5]), .D6(db[6]), .D7(db[7]), .D8(db[8])
    );

    // Reference: decimal digits by repeated division, ovf from the 10^ndig bound.
    function automatic exp_t model(input longint unsigned v, input int ndig);
        exp_t            e;
        longint unsigned p  = 1;
        longint unsigned vt = v;
        e = '0;
        for (int k = 0; k < ndig; k++) p = p * 10;
        e.ovf = (v >= p);
        for (int k = 0; k < ndig; k++) begin
            e.d[k] = 4'(vt % 10);
            vt     = vt / 10;
        end
`ifdef BIN2BCD_OVF_SAT_EN
        if (e.ovf) for (int k = 0; k < ndig; k++) e.d[k] = 4'd9;
`endif
        return e;
    endfunction

    function automatic logic done_of(input bit sel);
        return sel ? done_b : done_a;
    endfunction

    function automatic logic busy_of(input bit sel);
        return sel ? busy_b : busy_a;
    endfunction

    function automatic exp_t obs_of(input bit sel);
        exp_t o;
        o.ovf = sel ? ovf_b : ovf_a;
        o.d   = sel ? db : da;
        return o;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered at a negedge; leaves at the first sample after the acceptance edge.
    task automatic start_conv(input bit sel, input logic [31:0] v, input bit push, input bit hold);
        if (sel) begin
            start_b = 1'b1;
            bin_b   = v;
            if (push) sb.push_back(model(64'(v), 9));
        end else begin
            start_a = 1'b1;
            bin_a   = v[26:0];
            if (push) sb.push_back(model(64'(v[26:0]), 8));
        end
        @(negedge clk);
        if (!hold) begin
            if (sel) start_b = 1'b0;
            else     start_a = 1'b0;
        end
        if (sel) bin_b = $urandom;
        else     bin_a = 27'($urandom);
    endtask

    task automatic wait_done(input bit sel, input int k0, output int lat, output int bcnt);
        int k = k0;
        bcnt = 0;
        lat  = -1;
        while (k < 200) begin
            if (done_of(sel)) begin
                lat = k + 1;
                break;
            end
            if (busy_of(sel)) bcnt++;
            @(negedge clk);
            k++;
        end
    endtask

    task automatic finish_check(input bit sel, input string tag, input int lat, input int bcnt,
                                input bit chk_busy);
        exp_t e;
        exp_t o;
        int   lat_exp = sel ? 34 : 29;
        check({tag, "_lat"}, 64'(lat), 64'(lat_exp));
        if (chk_busy) check({tag, "_busy"}, 64'(bcnt), 64'(lat_exp - 1));
        if (sb.size() != 0) e = sb.pop_front();
        else                e = '1;
        o = obs_of(sel);
        check({tag, "_dig"}, 64'(o.d), 64'(e.d));
        check({tag, "_ovf"}, 64'(o.ovf), 64'(e.ovf));
        @(negedge clk);
        check({tag, "_pulse"}, 64'(done_of(sel)), 64'(0));
    endtask

    task automatic conv(input bit sel, input logic [31:0] v, input string tag);
        int lat;
        int bcnt;
        start_conv(sel, v, 1'b1, 1'b0);
        wait_done(sel, 0, lat, bcnt);
        finish_check(sel, tag, lat, bcnt, 1'b1);
    endtask

    initial begin
        int lat, bcnt, t1, t2, dcnt;

        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_a", 64'({busy_a, done_a, ovf_a, da}), 64'(0));
        check("rst_b", 64'({busy_b, done_b, ovf_b, db}), 64'(0));
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_a", 64'({busy_a, done_a, ovf_a, da}), 64'(0));

        conv(1'b0, 32'd12345678, "c12345678");
        conv(1'b0, 32'd0, "c0");
        conv(1'b0, 32'd99999999, "c99999999");
        conv(1'b0, 32'd100000000, "c_ovf");

        // Second start at E5 with a different value must be dropped.
        start_conv(1'b0, 32'd42, 1'b1, 1'b0);
        bin_a = 27'd7;
        repeat (4) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done(1'b0, 5, lat, bcnt);
        finish_check(1'b0, "busy_ign", lat, bcnt, 1'b0);
        check("no_queue", 64'(busy_a), 64'(0));
        repeat (2) @(negedge clk);

        // start held through done: the next conversion starts in the done cycle.
        start_conv(1'b0, 32'd5000000, 1'b1, 1'b1);
        bin_a = 27'd76543210;
        wait_done(1'b0, 0, lat, bcnt);
        t1 = cyc;
        finish_check(1'b0, "b2b1", lat, bcnt, 1'b1);
        sb.push_back(model(64'd76543210, 8));
        start_a = 1'b0;
        wait_done(1'b0, 0, lat, bcnt);
        t2 = cyc;
        finish_check(1'b0, "b2b2", lat, bcnt, 1'b1);
        check("b2b_period", 64'(t2 - t1), 64'(29));

        // Reset mid-conversion aborts immediately and produces no done.
        start_conv(1'b0, 32'd123456, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        check("mid_busy", 64'(busy_a), 64'(1));
        rst = 1'b0;
        #1;
        check("mid_rst", 64'({busy_a, done_a, ovf_a, da}), 64'(0));
        @(negedge clk);
        rst  = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 35; i++) begin
            @(negedge clk);
            if (done_a || busy_a) dcnt++;
        end
        check("mid_nodone", 64'(dcnt), 64'(0));
        conv(1'b0, 32'd305, "c305");

        conv(1'b1, 32'hFFFFFFFF, "w_max");
        conv(1'b1, 32'd987654321, "w_dig");
        check("sb_empty", 64'(sb.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
